// File: rtl/serial_add_ctrl_pkg.sv
// serial_add_ctrl_pkg: shared definitions for the bit-serial add/subtract
// controller. Holds the FSM state encoding used by the top and by anything
// that needs to decode the controller state.
package serial_add_ctrl_pkg;

  // Only these three codes are meaningful; 2'b11 is treated as IDLE.
  typedef enum logic [1:0] {
    ST_IDLE = 2'b00,
    ST_RUN  = 2'b01,
    ST_DONE = 2'b10
  } state_t;

endpackage

// File: rtl/serial_add_ctrl_fulladder.sv
// FullAdder: one-bit full adder cell, the only arithmetic datapath element
// of the serial controller.
//   In1, In2 : operand bits
//   Cin      : carry in
//   Sum      : sum bit
//   Cout     : carry out
module FullAdder (
  input  logic In1,
  input  logic In2,
  input  logic Cin,
  output logic Sum,
  output logic Cout
);

  logic w_p;

  assign w_p  = In1 ^ In2;
  assign Sum  = w_p ^ Cin;
  assign Cout = (In1 & In2) | (Cin & w_p);

endmodule

// File: rtl/serial_add_ctrl.sv
// serial_add_ctrl: bit-serial add/subtract controller. Sequences one
// FullAdder over WIDTH-bit operands, LSB first, one bit per clock.
//   Clk, Rst_n      : clock, asynchronous active-low reset
//   Start           : request, sampled only in IDLE
//   Sub             : 0 = A+B+CinInit, 1 = A-B
//   CinInit         : add-mode carry in
//   A, B            : operands, sampled with Start
//   Busy            : high in RUN and DONE
//   Done            : one-cycle pulse on completion
//   Sum, Cout       : registered result and carry out of the MSB
//   Overflow        : two's-complement overflow of the last result
module serial_add_ctrl
  import serial_add_ctrl_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic             Clk,
  input  logic             Rst_n,
  input  logic             Start,
  input  logic             Sub,
  input  logic             CinInit,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  output logic             Busy,
  output logic             Done,
  output logic [WIDTH-1:0] Sum,
  output logic             Cout,
  output logic             Overflow
);

  localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

  state_t           r_state, w_next;
  logic [CW-1:0]    r_cnt;
  logic [WIDTH-1:0] r_opa, r_opb, r_sum;
  // Partial result holds the WIDTH-1 bits already produced; the bit being
  // produced this cycle is prepended to form the full candidate result.
  logic [WIDTH-2:0] r_part;
  logic             r_carry, r_msb_cin, r_cout;
  logic             w_fa_sum, w_fa_cout, w_last;
  logic [WIDTH-1:0] w_acc;

  FullAdder u_fa (
    .In1  (r_opa[0]),
    .In2  (r_opb[0]),
    .Cin  (r_carry),
    .Sum  (w_fa_sum),
    .Cout (w_fa_cout)
  );

  assign w_last = (r_cnt == LAST);
  assign w_acc  = {w_fa_sum, r_part};

  always_ff @(posedge Clk or negedge Rst_n) begin
    if (!Rst_n) r_state <= ST_IDLE;
    else        r_state <= w_next;
  end

  always_comb begin
    w_next = ST_IDLE;
    Busy   = 1'b0;
    Done   = 1'b0;
    case (r_state)
      ST_IDLE: w_next = Start ? ST_RUN : ST_IDLE;
      ST_RUN: begin
        Busy   = 1'b1;
        w_next = w_last ? ST_DONE : ST_RUN;
      end
      ST_DONE: begin
        Busy = 1'b1;
        Done = 1'b1;
      end
      default: w_next = ST_IDLE;
    endcase
  end

  always_ff @(posedge Clk or negedge Rst_n) begin
    if (!Rst_n) begin
      r_cnt     <= '0;
      r_opa     <= '0;
      r_opb     <= '0;
      r_part    <= '0;
      r_carry   <= 1'b0;
      r_msb_cin <= 1'b0;
      r_sum     <= '0;
      r_cout    <= 1'b0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (Start) begin
            r_opa   <= A;
            r_opb   <= Sub ? ~B : B;
            // Subtract is A + ~B + 1; CinInit only matters for add.
            r_carry <= Sub | CinInit;
            r_cnt   <= '0;
          end
        end
        ST_RUN: begin
          r_opa   <= r_opa >> 1;
          r_opb   <= r_opb >> 1;
          r_part  <= w_acc[WIDTH-1:1];
          r_carry <= w_fa_cout;
          r_cnt   <= r_cnt + 1'b1;
          // Results are committed only on the final bit so the outputs
          // never expose a partial sum.
          if (w_last) begin
            r_msb_cin <= r_carry;
            r_sum     <= w_acc;
            r_cout    <= w_fa_cout;
          end
        end
        default: ;
      endcase
    end
  end

  assign Sum      = r_sum;
  assign Cout     = r_cout;
  // Both terms are registers loaded on the same edge, so this only changes
  // on DONE entry or reset.
  assign Overflow = r_msb_cin ^ r_cout;

endmodule

// File: tb/tb_serial_add_ctrl.sv
module tb_serial_add_ctrl;

  logic Clk = 1'b0;
  always #5 Clk = ~Clk;

  logic       Rst_n, Sub, Cin, St8, St4, St2;
  logic [7:0] A8, B8, Sum8;
  logic [3:0] A4, B4, Sum4;
  logic [1:0] A2, B2, Sum2;
  logic       Busy8, Done8, Cout8, Ov8;
  logic       Busy4, Done4, Cout4, Ov4;
  logic       Busy2, Done2, Cout2, Ov2;

  serial_add_ctrl #(.WIDTH(8)) u_w8 (
    .Clk(Clk), .Rst_n(Rst_n), .Start(St8), .Sub(Sub), .CinInit(Cin), .A(A8), .B(B8),
    .Busy(Busy8), .Done(Done8), .Sum(Sum8), .Cout(Cout8), .Overflow(Ov8));
  serial_add_ctrl #(.WIDTH(4)) u_w4 (
    .Clk(Clk), .Rst_n(Rst_n), .Start(St4), .Sub(Sub), .CinInit(Cin), .A(A4), .B(B4),
    .Busy(Busy4), .Done(Done4), .Sum(Sum4), .Cout(Cout4), .Overflow(Ov4));
  serial_add_ctrl #(.WIDTH(2)) u_w2 (
    .Clk(Clk), .Rst_n(Rst_n), .Start(St2), .Sub(Sub), .CinInit(Cin), .A(A2), .B(B2),
    .Busy(Busy2), .Done(Done2), .Sum(Sum2), .Cout(Cout2), .Overflow(Ov2));

  typedef struct {
    logic [7:0] sum;
    logic       cout;
    logic       ov;
    int         cyc;
  } exp_t;

  typedef struct {
    logic       sub;
    logic       cin;
    logic [7:0] a;
    logic [7:0] b;
    logic [7:0] sum;
    logic       cout;
    logic       ov;
  } vec_t;

  exp_t q8[$], q4[$], q2[$];
  exp_t e8, e4, e2;
  int   cyc = 0;
  int   n_vec = 0;
  int   n_err = 0;

  always @(posedge Clk) cyc <= cyc + 1;

  task automatic chk(string nm, logic [31:0] got, logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", nm, got, exp, $time);
    end
  endtask

  // Behavioural reference: whole-word addition with the sign rule for overflow.
  function automatic exp_t model(int w, logic sub, logic cin, logic [7:0] a, logic [7:0] b);
    logic [32:0] m, av, bx, full;
    exp_t e;
    m    = (33'd1 << w) - 33'd1;
    av   = {25'd0, a} & m;
    bx   = (sub ? ~{25'd0, b} : {25'd0, b}) & m;
    full = av + bx + (sub ? 33'd1 : {32'd0, cin});
    e.sum  = full[7:0] & m[7:0];
    e.cout = full[w];
    e.ov   = (av[w-1] == bx[w-1]) && (full[w-1] != av[w-1]);
    e.cyc  = 0;
    return e;
  endfunction

  // Scoreboard monitors: every Done pops one expected record.
  always @(negedge Clk) if (Done8 === 1'b1) begin
    if (q8.size() == 0) chk("w8 unexpected Done", Done8, 0);
    else begin
      e8 = q8.pop_front();
      chk("w8 sum", Sum8, e8.sum); chk("w8 cout", Cout8, e8.cout);
      chk("w8 ovf", Ov8, e8.ov);   chk("w8 done cycle", cyc, e8.cyc);
    end
  end
  always @(negedge Clk) if (Done4 === 1'b1) begin
    if (q4.size() == 0) chk("w4 unexpected Done", Done4, 0);
    else begin
      e4 = q4.pop_front();
      chk("w4 sum", Sum4, e4.sum); chk("w4 cout", Cout4, e4.cout);
      chk("w4 ovf", Ov4, e4.ov);   chk("w4 done cycle", cyc, e4.cyc);
    end
  end
  always @(negedge Clk) if (Done2 === 1'b1) begin
    if (q2.size() == 0) chk("w2 unexpected Done", Done2, 0);
    else begin
      e2 = q2.pop_front();
      chk("w2 sum", Sum2, e2.sum); chk("w2 cout", Cout2, e2.cout);
      chk("w2 ovf", Ov2, e2.ov);   chk("w2 done cycle", cyc, e2.cyc);
    end
  end

  function automatic int qsize(int w);
    case (w)
      8: return q8.size();
      4: return q4.size();
      default: return q2.size();
    endcase
  endfunction

  task automatic qclear(int w);
    case (w)
      8: q8.delete();
      4: q4.delete();
      default: q2.delete();
    endcase
  endtask

  function automatic logic busy_of(int w);
    case (w)
      8: return Busy8;
      4: return Busy4;
      default: return Busy2;
    endcase
  endfunction

  function automatic logic done_of(int w);
    case (w)
      8: return Done8;
      4: return Done4;
      default: return Done2;
    endcase
  endfunction

  // Wait (bounded) until the scoreboard for width w drains, then confirm
  // the controller dropped back to idle right after the Done pulse.
  task automatic wait_done(int w);
    int t = 0;
    while (qsize(w) != 0 && t < 40) begin
      @(posedge Clk); #1; t++;
    end
    if (qsize(w) != 0) begin
      chk($sformatf("w%0d done timeout", w), qsize(w), 0);
      qclear(w);
    end else begin
      chk($sformatf("w%0d busy after done", w), busy_of(w), 0);
      chk($sformatf("w%0d done width", w), done_of(w), 0);
    end
  endtask

  task automatic run_op(int w, logic sub, logic cin, logic [7:0] a, logic [7:0] b, exp_t e);
    @(negedge Clk);
    Sub = sub; Cin = cin;
    e.cyc = cyc + 1 + w;
    case (w)
      8: begin A8 = a; B8 = b; St8 = 1'b1; q8.push_back(e); end
      4: begin A4 = a[3:0]; B4 = b[3:0]; St4 = 1'b1; q4.push_back(e); end
      default: begin A2 = a[1:0]; B2 = b[1:0]; St2 = 1'b1; q2.push_back(e); end
    endcase
    @(negedge Clk);
    St8 = 1'b0; St4 = 1'b0; St2 = 1'b0;
    chk($sformatf("w%0d busy after start", w), busy_of(w), 1);
    wait_done(w);
  endtask

  vec_t vt[7];

  initial begin
    exp_t e;
    Rst_n = 1'b0; St8 = 0; St4 = 0; St2 = 0; Sub = 0; Cin = 0;
    A8 = 0; B8 = 0; A4 = 0; B4 = 0; A2 = 0; B2 = 0;

    vt[0] = '{1'b0, 1'b0, 8'h5A, 8'h33, 8'h8D, 1'b0, 1'b1};
    vt[1] = '{1'b0, 1'b0, 8'hFF, 8'h01, 8'h00, 1'b1, 1'b0};
    vt[2] = '{1'b0, 1'b1, 8'hFF, 8'h00, 8'h00, 1'b1, 1'b0};
    vt[3] = '{1'b1, 1'b0, 8'h10, 8'h20, 8'hF0, 1'b0, 1'b0};
    vt[4] = '{1'b1, 1'b0, 8'h80, 8'h01, 8'h7F, 1'b1, 1'b1};
    vt[5] = '{1'b0, 1'b1, 8'h7F, 8'h00, 8'h80, 1'b0, 1'b1};
    vt[6] = '{1'b1, 1'b1, 8'h05, 8'h05, 8'h00, 1'b1, 1'b0};

    // Reset state
    repeat (3) @(negedge Clk);
    chk("reset busy", Busy8, 0); chk("reset done", Done8, 0);
    chk("reset sum", Sum8, 0);   chk("reset cout", Cout8, 0);
    chk("reset ovf", Ov8, 0);
    Rst_n = 1'b1;
    repeat (2) @(negedge Clk);

    // Directed table, WIDTH=8
    for (int i = 0; i < 7; i++) begin
      e = '{vt[i].sum, vt[i].cout, vt[i].ov, 0};
      run_op(8, vt[i].sub, vt[i].cin, vt[i].a, vt[i].b, e);
    end

    // Random WIDTH=8 against the reference
    for (int i = 0; i < 24; i++) begin
      logic s, c;
      logic [7:0] a, b;
      s = 1'($urandom_range(1)); c = 1'($urandom_range(1));
      a = 8'($urandom_range(255)); b = 8'($urandom_range(255));
      run_op(8, s, c, a, b, model(8, s, c, a, b));
    end

    // Start/operand changes while busy are ignored
    @(negedge Clk);
    Sub = 0; Cin = 0; A8 = 8'h12; B8 = 8'h34; St8 = 1'b1;
    e = '{8'h46, 1'b0, 1'b0, cyc + 9}; q8.push_back(e);
    @(negedge Clk) St8 = 1'b0;
    repeat (2) @(negedge Clk);
    St8 = 1'b1; A8 = 8'hFF; B8 = 8'hFF; Sub = 1'b1;
    @(negedge Clk) St8 = 1'b0;
    repeat (4) @(negedge Clk);
    St8 = 1'b1; A8 = 8'h00; B8 = 8'h00;
    @(negedge Clk) St8 = 1'b0;
    wait_done(8);
    repeat (12) @(negedge Clk);

    // Start held high: a new operation every WIDTH+2 cycles
    @(negedge Clk);
    Sub = 0; Cin = 0; A8 = 8'h5A; B8 = 8'h33; St8 = 1'b1;
    for (int i = 0; i < 3; i++) begin
      e = '{8'h8D, 1'b0, 1'b1, cyc + 9 + 10 * i};
      q8.push_back(e);
    end
    repeat (21) @(negedge Clk);
    St8 = 1'b0;
    wait_done(8);

    // Reset mid-operation: outputs clear at once, no Done follows
    @(negedge Clk);
    A8 = 8'h01; B8 = 8'h02; Sub = 0; Cin = 0; St8 = 1'b1;
    e = '{8'h03, 1'b0, 1'b0, cyc + 9}; q8.push_back(e);
    @(negedge Clk) St8 = 1'b0;
    repeat (3) @(negedge Clk);
    Rst_n = 1'b0;
    #1;
    chk("midreset busy", Busy8, 0); chk("midreset done", Done8, 0);
    chk("midreset sum", Sum8, 0);   chk("midreset cout", Cout8, 0);
    chk("midreset ovf", Ov8, 0);
    q8.delete();
    repeat (2) @(negedge Clk);
    Rst_n = 1'b1;
    repeat (12) @(negedge Clk);
    e = '{8'h02, 1'b0, 1'b0, 0};
    run_op(8, 1'b0, 1'b0, 8'h01, 8'h01, e);

    // Exhaustive narrow widths
    for (int w = 2; w <= 4; w += 2)
      for (int a = 0; a < (1 << w); a++)
        for (int b = 0; b < (1 << w); b++)
          for (int m = 0; m < 4; m++)
            run_op(w, m[1], m[0], 8'(a), 8'(b), model(w, m[1], m[0], 8'(a), 8'(b)));

    repeat (4) @(negedge Clk);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
